// File: rtl/rowmatrix_out_drain.sv
// Output drain for the row-matrix PU: captures the accumulator vector on a rising PU done,
// requantizes every column and streams them out column 0 first over a valid/ready handshake.
module rowmatrix_out_drain #(
  parameter int unsigned NUM_COL     = 8,
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned SHIFT_WIDTH = 4,
  localparam int unsigned IDX_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_pu_done,
  input  logic [NUM_COL*IN_WIDTH-1:0]   i_pu_out,
  input  logic [SHIFT_WIDTH-1:0]        i_shift,
  output logic                          o_m_valid,
  input  logic                          i_m_ready,
  output logic [OUT_WIDTH-1:0]          o_m_data,
  output logic [IDX_W-1:0]              o_m_idx,
  output logic                          o_m_last,
  output logic                          o_busy,
  output logic                          o_drain_done,
  output logic                          o_overrun
);

  typedef enum logic {StIdle, StSend} state_e;

  // Clamp bounds held in IN_WIDTH+1 bits so they compare directly against the shifted sum.
  localparam logic signed [IN_WIDTH:0] MAX_V = (IN_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH:0] MIN_V = ~MAX_V;

  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [IN_WIDTH-1:0] x,
                                                   input logic [SHIFT_WIDTH-1:0]   s);
    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] t;
    logic signed [IN_WIDTH:0] y;
    rnd = '0;
    if (s != '0) rnd = {{IN_WIDTH{1'b0}}, 1'b1} << (s - SHIFT_WIDTH'(1));
    // Extra sign bit keeps x + rounding from wrapping at the positive limit.
    t = {x[IN_WIDTH-1], x} + rnd;
    y = t >>> s;
    if (y > MAX_V) begin
      requant = MAX_V[OUT_WIDTH-1:0];
    end else if (y < MIN_V) begin
      requant = MIN_V[OUT_WIDTH-1:0];
    end else begin
      requant = y[OUT_WIDTH-1:0];
    end
  endfunction

  logic [OUT_WIDTH-1:0] w_q [NUM_COL];
  logic                 w_capture;
  logic                 w_beat;

  state_e               r_state;
  logic                 r_done_d;
  logic [OUT_WIDTH-1:0] r_q [NUM_COL];
  logic                 r_valid;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_drain_done;
  logic                 r_overrun;

  for (genvar g = 0; g < NUM_COL; g++) begin : g_requant
    assign w_q[g] = requant(i_pu_out[IN_WIDTH*g +: IN_WIDTH], i_shift);
  end

  assign w_capture = i_pu_done & ~r_done_d;
  assign w_beat    = r_valid & i_m_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_done_d     <= 1'b0;
      r_valid      <= 1'b0;
      r_idx        <= '0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_drain_done <= 1'b0;
      r_overrun    <= 1'b0;
      for (int j = 0; j < NUM_COL; j++) r_q[j] <= '0;
    end else begin
      r_done_d     <= i_pu_done;
      r_drain_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_capture) begin
            r_q     <= w_q;
            r_state <= StSend;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_last  <= (NUM_COL == 1);
          end
        end
        StSend: begin
          // A new vector cannot be taken while one is held; flag it instead.
          if (w_capture) r_overrun <= 1'b1;
          if (w_beat) begin
            if (r_last) begin
              r_state      <= StIdle;
              r_valid      <= 1'b0;
              r_busy       <= 1'b0;
              r_drain_done <= 1'b1;
              r_idx        <= '0;
              r_last       <= 1'b0;
            end else begin
              r_idx  <= r_idx + IDX_W'(1);
              r_last <= (r_idx + IDX_W'(1)) == IDX_W'(NUM_COL - 1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_m_valid    = r_valid;
  assign o_m_data     = r_valid ? r_q[r_idx] : '0;
  assign o_m_idx      = r_idx;
  assign o_m_last     = r_last;
  assign o_busy       = r_busy;
  assign o_drain_done = r_drain_done;
  assign o_overrun    = r_overrun;

endmodule
